// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: latch enables/flushes, PC enable, cache-port arbitration, halt.
// Optional event counters (stall_cnt, flush_cnt) are built when PIPE_PERF_EN is defined.
module pipe_hazard_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        exmem_dREN,
  input  logic        exmem_dWEN,
  input  logic        exmem_halt,
  input  logic        exmem_take,
  input  logic        idex_dREN,
  input  logic [4:0]  idex_wsel,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic        halt
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALT} state_t;

  state_t state, next;
  logic   dreq, load_use, take_evt;

  assign dreq     = exmem_dREN | exmem_dWEN;
  assign load_use = idex_dREN && (idex_wsel != 5'd0) &&
                    ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));

  always_comb begin
    next        = state;
    take_evt    = 1'b0;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    imemREN     = 1'b0;
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    unique case (state)
      RUN, DWAIT: begin
        dmemREN = exmem_dREN;
        dmemWEN = exmem_dWEN;
        imemREN = ~dreq;
        if (dreq && !dhit) begin
          memwb_flush = 1'b1;
          next        = DWAIT;
        end else begin
          // Latches advance by default; flushes below override the enable inside the latch.
          next     = RUN;
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
          if (exmem_halt) begin
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            next        = DRAIN;
          end else if (exmem_take) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            take_evt    = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (!dreq && !ihit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
          end
        end
      end
      DRAIN: begin
        memwb_en = 1'b1;
        next     = HALT;
      end
      HALT: ;
    endcase
    // Outputs are held quiet for the whole reset pulse, not just at the edge.
    if (!nRST) begin
      take_evt    = 1'b0;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      imemREN     = 1'b0;
      dmemREN     = 1'b0;
      dmemWEN     = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      halt  <= 1'b0;
    end else begin
      state <= next;
      halt  <= halt | (next == HALT);
    end
  end

`ifdef PIPE_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (!pc_en && state != HALT) stall_cnt <= stall_cnt + 32'd1;
      if (take_evt)                flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  logic unused_take;
  assign unused_take = take_evt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed test-plan sequences, then randomized inputs
// checked against a rule-priority reference model.
module tb_pipe_hazard_ctrl;
  logic CLK = 1'b0, nRST = 1'b0;
  logic ihit = 0, dhit = 0, exmem_dREN = 0, exmem_dWEN = 0, exmem_halt = 0, exmem_take = 0, idex_dREN = 0;
  logic [4:0] idex_wsel = 0, ifid_rs = 0, ifid_rt = 0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic imemREN, dmemREN, dmemWEN, halt;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .exmem_halt(exmem_halt), .exmem_take(exmem_take),
    .idex_dREN(idex_dREN), .idex_wsel(idex_wsel), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .halt(halt)
`ifdef PIPE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  logic [11:0] obs;
  assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush, imemREN, dmemREN, dmemWEN};

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which rule governs this cycle, then a fixed output pattern per rule.
  localparam int R_HALTED = 0, R_DRAIN = 1, R_MSTALL = 2, R_HALTMEM = 3,
                 R_TAKE = 4, R_LU = 5, R_FETCH = 6, R_ADV = 7;
  int          phase = 0;  // 0 running, 1 draining, 2 halted
  logic [31:0] m_stall = 0, m_flush = 0;

  function automatic int rule_of();
    logic dreq;
    dreq = exmem_dREN | exmem_dWEN;
    if (phase == 2) return R_HALTED;
    if (phase == 1) return R_DRAIN;
    if (dreq && !dhit) return R_MSTALL;
    if (exmem_halt) return R_HALTMEM;
    if (exmem_take) return R_TAKE;
    if (idex_dREN && idex_wsel != 0 && (idex_wsel == ifid_rs || idex_wsel == ifid_rt)) return R_LU;
    if (!dreq && !ihit) return R_FETCH;
    return R_ADV;
  endfunction

  // Pattern: {pc_en, en[if,id,ex,wb], flush[if,id,ex,wb]} then {imemREN, dmemREN, dmemWEN}
  function automatic logic [11:0] expect_out(input int r);
    logic [8:0] c;
    logic [2:0] rq;
    case (r)
      R_HALTED:  c = 9'b0_0000_0000;
      R_DRAIN:   c = 9'b0_0001_0000;
      R_MSTALL:  c = 9'b0_0000_0001;
      R_HALTMEM: c = 9'b0_1111_1110;
      R_TAKE:    c = 9'b1_1111_1110;
      R_LU:      c = 9'b0_0111_0100;
      R_FETCH:   c = 9'b0_0111_1000;
      default:   c = 9'b1_1111_0000;
    endcase
    if (r == R_HALTED || r == R_DRAIN) rq = 3'b000;
    else rq = {!(exmem_dREN | exmem_dWEN), exmem_dREN, exmem_dWEN};
    return {c, rq};
  endfunction

  task automatic set_in(input logic dr, input logic dw, input logic dh, input logic ih,
                        input logic hl, input logic tk, input logic ldr,
                        input logic [4:0] ws, input logic [4:0] rs, input logic [4:0] rt);
    exmem_dREN = dr; exmem_dWEN = dw; dhit = dh; ihit = ih; exmem_halt = hl;
    exmem_take = tk; idex_dREN = ldr; idex_wsel = ws; ifid_rs = rs; ifid_rt = rt;
  endtask

  // Inputs are applied at the negedge; check combinational outputs, clock, update model.
  task automatic step();
    int r;
    #1;
    r = rule_of();
    chk("ctl", 32'(obs), 32'(expect_out(r)));
    chk("halt", 32'(halt), 32'(phase == 2));
    @(posedge CLK);
    if (r == R_DRAIN || r == R_MSTALL || r == R_HALTMEM || r == R_LU || r == R_FETCH) m_stall++;
    if (r == R_TAKE) m_flush++;
    if (r == R_DRAIN) phase = 2;
    else if (r == R_HALTMEM) phase = 1;
    #1;
    chk("halt_q", 32'(halt), 32'(phase == 2));
`ifdef PIPE_PERF_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
`endif
    @(negedge CLK);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    chk("rst_ctl", 32'(obs), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
`ifdef PIPE_PERF_EN
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_flush", flush_cnt, 32'd0);
`endif
    phase = 0; m_stall = 0; m_flush = 0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    @(negedge CLK);
    set_in(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    do_reset();
    // Load with three miss cycles, then the hit, then fetch resumes
    repeat (3) step();
    set_in(1, 0, 1, 1, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); step();
    // Load-use on rs, on rt, then zero destination never stalls
    set_in(0, 0, 0, 1, 0, 0, 1, 5'd8, 5'd8, 5'd1); step();
    set_in(0, 0, 0, 1, 0, 0, 1, 5'd9, 5'd1, 5'd9); step();
    set_in(0, 0, 0, 1, 0, 0, 1, 5'd0, 5'd0, 5'd0); step();
    // Taken branch beats load-use and fetch miss; also together with a dhit
    set_in(0, 0, 0, 0, 0, 1, 1, 5'd8, 5'd8, 5'd8); step();
    set_in(1, 0, 1, 0, 0, 1, 1, 5'd8, 5'd8, 5'd8); step();
    // Store holds the port, then instruction fetch returns
    set_in(0, 1, 0, 1, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 1, 1, 1, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); step();
    // Memory stall wins over load-use; load-use reappears after
    set_in(1, 0, 0, 1, 0, 0, 1, 5'd3, 5'd3, 5'd0); step();
    set_in(1, 0, 1, 1, 0, 0, 1, 5'd3, 5'd3, 5'd0); step();
    set_in(0, 0, 0, 1, 0, 0, 1, 5'd3, 5'd3, 5'd0); step();
    // Reset in the middle of a data wait
    set_in(1, 0, 0, 1, 0, 0, 0, 0, 0, 0); step();
    do_reset();
    // Halt: drain, then halted and quiet regardless of inputs
    set_in(0, 0, 0, 1, 1, 0, 0, 0, 0, 0); step();
    set_in(1, 1, 0, 0, 0, 1, 1, 5'd2, 5'd2, 5'd2); repeat (3) step();
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if ((phase == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        int m;
        m = int'($urandom_range(0, 3));
        set_in(m == 0, m == 1, $urandom_range(0, 1) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 0,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        step();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
